rdlvl_lane_sequencer: RTL and testbench
=======================================

# rdlvl_lane_sequencer

Sequences read training across all byte lanes of the DDR PHY. On `start`, walks enabled lanes in ascending order; per lane, runs gate training (per-lane `dfi_rdlvl_gate_en`), then DQ/DQS training (per-lane `dfi_rdlvl_en`), and waits for that lane's training response between phases. Sits between the training front end and the per-lane `RDLVL_TRAIN` instances. Reports completion, first failing lane/phase, and timeouts.

## Interface
- `LANECOUNT`, 4: number of byte lanes, 1..8.
- `TMO_W`, 16: width of the per-phase timeout counter.
- `SETTLE_CYC`, 4: idle cycles between phases and lanes, 1..15.

- `SCLK` input 1: system clock.
- `reset_n` input 1: asynchronous active-low reset, synchronously deasserted upstream.
- `start` input 1: single-cycle request to begin a sweep; ignored while `busy`.
- `lane_mask` input LANECOUNT: lanes to train; sampled on accepted `start`.
- `timeout_limit` input TMO_W: maximum cycles per phase; 0 disables the timeout. Sampled on accepted `start`.
- `lane_resp` input LANECOUNT: per-lane `dfi_rdlvl_resp_internal` from the lane trainers.
- `lane_error` input LANECOUNT: per-lane `rd_training_error`.
- `gate_en` output LANECOUNT: per-lane `dfi_rdlvl_gate_en`; one-hot or zero.
- `rdlvl_en` output LANECOUNT: per-lane `dfi_rdlvl_en`; one-hot or zero.
- `busy` output 1: sweep in progress.
- `done` output 1: sweep finished without failure; held until the next accepted `start`.
- `fail` output 1: sweep aborted; held until the next accepted `start`.
- `fail_lane` output 3: lane index of the failure.
- `fail_cause` output 2: 01 = lane error; 10 = timeout; 00 = no failure.
- `fail_phase` output 1: 0 = gate phase, 1 = DQ/DQS phase.
- `cur_lane` output 3: lane currently being trained.

## Operation
- States: IDLE, SELECT, GATE, SETTLE_G, RDLVL, SETTLE_R, DONE, FAIL.
- IDLE/DONE/FAIL + `start`:
  - Latch `lane_mask` and `timeout_limit`.
  - Clear `done`, `fail`, and `fail_*`.
  - Set `busy`, go to SELECT with the search index at 0.
- SELECT:
  - Find the lowest set mask bit at or above the index and load it into `cur_lane`, then go to GATE.
  - If no bit is set, go to DONE (this covers an all-zero mask).
  - The search is combinational, one cycle.
- GATE: `gate_en[cur_lane]`=1; timeout counter counts up from 0.
  - `lane_error[cur_lane]` → FAIL. Error has priority over a same-cycle response.
  - `lane_resp[cur_lane]` → SETTLE_G.
  - Counter reaches `timeout_limit` (nonzero) → FAIL.
- SETTLE_G: all enables low for SETTLE_CYC cycles, then RDLVL. The counter is reused.
- RDLVL: same as GATE, using `rdlvl_en[cur_lane]`; response → SETTLE_R.
- SETTLE_R: SETTLE_CYC cycles with all enables low; index = `cur_lane`+1; go to SELECT.
- The index saturates at LANECOUNT, which yields DONE.
- DONE: `done`=1, `busy`=0.
- FAIL:
  - `fail`=1, `busy`=0.
  - `fail_lane` = `cur_lane`; `fail_phase` = phase at abort; `fail_cause` set.
  - All enables deasserted.
- Responses and errors from lanes other than `cur_lane` are ignored.
- Responses outside GATE/RDLVL are ignored.

## Timing
- Reset values: all outputs 0; state IDLE.
- `start` at cycle N → `busy`=1 at N+1; SELECT at N+1; first `gate_en` at N+2.
- `lane_resp` sampled high at cycle M → enable low at M+1.
  - Next phase's enable rises at M+1+SETTLE_CYC.
- Timeout: enable asserted for exactly `timeout_limit` cycles, then FAIL registered.
- `done`/`fail` are registered and rise one cycle after the terminal condition; `busy` falls on the same edge.
- A `start` during `busy` has no effect, including in the same cycle as completion.
- Asynchronous reset mid-sweep: all enables drop immediately; state returns to IDLE; no partial results are kept.

## Test plan
- Mask 4'b1011, lanes respond 10 cycles after enable, SETTLE_CYC=4 → order: gate0, rdlvl0, gate1, rdlvl1, gate3, rdlvl3.
  - Lane 2 enables never assert.
  - `done`=1, `fail`=0; total enable-high cycles = 6×11.
- Mask 0 with `start` → `done` 2 cycles later; no enable ever asserted.
- Lane 1 with `timeout_limit`=20, `lane_resp` never asserted in RDLVL → `rdlvl_en[1]` high exactly 20 cycles.
  - Then `fail`=1, `fail_lane`=1, `fail_cause`=10, `fail_phase`=1.
- `lane_error[0]` and `lane_resp[0]` high in the same cycle in GATE → FAIL with `fail_cause`=01, `fail_phase`=0.
- Stray and mid-sweep inputs during a sweep:
  - `lane_resp[2]` pulsed while lane 0 trains → no effect.
  - Second `start` mid-sweep → ignored.
  - `reset_n` low mid-GATE → enables and `busy` drop asynchronously; next `start` restarts at lane 0.
- `timeout_limit`=0 with response after 70000 cycles → no timeout; sweep completes with `done`=1.

Source files
------------

// File: rtl/rdlvl_lane_sequencer.sv
// rdlvl_lane_sequencer
// Walks the enabled byte lanes in ascending order. For each lane it runs gate
// training and then DQ/DQS training, and inserts an idle settle gap after each
// phase. It reports sweep completion, or the lane, phase and cause of the first
// failure.
module rdlvl_lane_sequencer #(
  parameter int LANECOUNT  = 4,
  parameter int TMO_W      = 16,
  parameter int SETTLE_CYC = 4
) (
  input  logic                 SCLK,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [LANECOUNT-1:0] lane_mask,
  input  logic [TMO_W-1:0]     timeout_limit,
  input  logic [LANECOUNT-1:0] lane_resp,
  input  logic [LANECOUNT-1:0] lane_error,
  output logic [LANECOUNT-1:0] gate_en,
  output logic [LANECOUNT-1:0] rdlvl_en,
  output logic                 busy,
  output logic                 done,
  output logic                 fail,
  output logic [2:0]           fail_lane,
  output logic [1:0]           fail_cause,
  output logic                 fail_phase,
  output logic [2:0]           cur_lane
);

  typedef enum logic [2:0] {
    IDLE, SELECT, GATE, SETTLE_G, RDLVL, SETTLE_R, DONE, FAIL
  } state_t;

  state_t               state, state_nxt;
  logic [LANECOUNT-1:0] mask_q;
  logic [TMO_W-1:0]     tmo_q;
  logic [TMO_W-1:0]     cnt;
  logic [3:0]           search_idx;
  logic                 sel_found;
  logic [2:0]           sel_lane;
  logic                 cur_resp;
  logic                 cur_err;
  logic                 tmo_hit;
  logic                 settle_hit;
  logic                 accept_start;

  // Find the next lane to train, and pick out the active lane's response and error.
  always_comb begin
    sel_found = 1'b0;
    sel_lane  = 3'd0;
    cur_resp  = 1'b0;
    cur_err   = 1'b0;
    for (int i = 0; i < LANECOUNT; i++) begin
      if (!sel_found && mask_q[i] && (4'(i) >= search_idx)) begin
        sel_found = 1'b1;
        sel_lane  = 3'(i);
      end
      if (cur_lane == 3'(i)) begin
        cur_resp = lane_resp[i];
        cur_err  = lane_error[i];
      end
    end
  end

  assign tmo_hit      = (tmo_q != '0) && ((cnt + TMO_W'(1)) == tmo_q);
  assign settle_hit   = (cnt == TMO_W'(SETTLE_CYC - 1));
  assign accept_start = start && ((state == IDLE) || (state == DONE) || (state == FAIL));

  // State register. An asynchronous reset aborts any sweep in progress.
  always_ff @(posedge SCLK or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic. Within a phase, a lane error wins over a response, and a
  // response wins over a timeout.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE, FAIL: if (accept_start) state_nxt = SELECT;
      SELECT:   state_nxt = sel_found ? GATE : DONE;
      GATE: begin
        if (cur_err)       state_nxt = FAIL;
        else if (cur_resp) state_nxt = SETTLE_G;
        else if (tmo_hit)  state_nxt = FAIL;
      end
      SETTLE_G: if (settle_hit) state_nxt = RDLVL;
      RDLVL: begin
        if (cur_err)       state_nxt = FAIL;
        else if (cur_resp) state_nxt = SETTLE_R;
        else if (tmo_hit)  state_nxt = FAIL;
      end
      SETTLE_R: if (settle_hit) state_nxt = SELECT;
      default:  state_nxt = IDLE;
    endcase
  end

  // Sweep datapath. The counter restarts on every state change, and the sweep
  // setup plus the failure record are captured at the transitions.
  always_ff @(posedge SCLK or negedge reset_n) begin
    if (!reset_n) begin
      mask_q     <= '0;
      tmo_q      <= '0;
      cnt        <= '0;
      search_idx <= '0;
      cur_lane   <= '0;
      fail_lane  <= '0;
      fail_cause <= '0;
      fail_phase <= 1'b0;
    end else begin
      if (state_nxt != state) cnt <= '0;
      else                    cnt <= cnt + TMO_W'(1);

      if (accept_start) begin
        mask_q     <= lane_mask;
        tmo_q      <= timeout_limit;
        search_idx <= '0;
        cur_lane   <= '0;
        fail_lane  <= '0;
        fail_cause <= '0;
        fail_phase <= 1'b0;
      end

      if ((state == SELECT) && sel_found) cur_lane <= sel_lane;

      if ((state == SETTLE_R) && settle_hit) search_idx <= {1'b0, cur_lane} + 4'd1;

      if ((state_nxt == FAIL) && (state != FAIL)) begin
        fail_lane  <= cur_lane;
        fail_phase <= (state == RDLVL);
        fail_cause <= cur_err ? 2'b01 : 2'b10;
      end
    end
  end

  // Output decode. Enables are one-hot on the active lane and are driven only
  // while a training phase is running.
  always_comb begin
    gate_en  = '0;
    rdlvl_en = '0;
    for (int i = 0; i < LANECOUNT; i++) begin
      gate_en[i]  = (state == GATE)  && (cur_lane == 3'(i));
      rdlvl_en[i] = (state == RDLVL) && (cur_lane == 3'(i));
    end
    busy = (state == SELECT) || (state == GATE) || (state == SETTLE_G) ||
           (state == RDLVL) || (state == SETTLE_R);
    done = (state == DONE);
    fail = (state == FAIL);
  end

endmodule

// File: tb/tb_rdlvl_lane_sequencer.sv
// tb_rdlvl_lane_sequencer
// Directed bench for the lane sequencer. A small lane model answers each enable
// after a programmable delay. Every scenario checks phase order, enable
// durations, settle gaps and the final status against hand-computed values.
module tb_rdlvl_lane_sequencer;

  logic       SCLK = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] lane_mask = '0;
  logic [15:0] timeout_limit = '0;
  logic [3:0] lane_resp;
  logic [3:0] lane_error = '0;
  logic [3:0] gate_en, rdlvl_en;
  logic       busy, done, fail, fail_phase;
  logic [2:0] fail_lane, cur_lane;
  logic [1:0] fail_cause;

  logic [3:0] auto_resp = '0;
  logic [3:0] stray_resp = '0;
  assign lane_resp = auto_resp | stray_resp;

  int vectors = 0;
  int miscompares = 0;

  int gate_delay = 10;
  int rdlvl_delay = 10;
  int restart_at = -1;
  logic [3:0] restart_mask = '0;
  int stray_at = -1;
  logic [3:0] stray_vec = '0;
  int error_at = -1;
  logic [3:0] error_vec = '0;
  logic [3:0] forbid = '0;

  logic [7:0] order[$];
  int durs[$];
  int gaps[$];
  int en_total, onehot_bad, forbid_hits, end_k;
  logic busy_k1, done_k1, fail_k1;

  logic [7:0] rsp_prev = '0;
  logic [7:0] rsp_now;
  int rsp_age = 0;
  int rsp_delay;

  rdlvl_lane_sequencer #(.LANECOUNT(4), .TMO_W(16), .SETTLE_CYC(4)) dut (
    .SCLK(SCLK), .reset_n(reset_n), .start(start), .lane_mask(lane_mask),
    .timeout_limit(timeout_limit), .lane_resp(lane_resp), .lane_error(lane_error),
    .gate_en(gate_en), .rdlvl_en(rdlvl_en), .busy(busy), .done(done), .fail(fail),
    .fail_lane(fail_lane), .fail_cause(fail_cause), .fail_phase(fail_phase),
    .cur_lane(cur_lane)
  );

  always #5 SCLK = ~SCLK;

  // Lane model: pulse the response of the enabled lane once that enable has been high for the programmed delay.
  always @(negedge SCLK) begin
    rsp_now = {rdlvl_en, gate_en};
    if (rsp_now == 8'h00 || rsp_now != rsp_prev) rsp_age = 0;
    else rsp_age++;
    rsp_prev = rsp_now;
    rsp_delay = (rdlvl_en != 4'b0) ? rdlvl_delay : gate_delay;
    if (rsp_now != 8'h00 && rsp_delay >= 0 && rsp_age == rsp_delay) auto_resp = gate_en | rdlvl_en;
    else auto_resp = '0;
  end

  task automatic run_sweep(input logic [3:0] mask, input logic [15:0] limit, input int max_k);
    logic [7:0] cur, prev;
    int run_len, gap_len;
    bit seen;
    order.delete(); durs.delete(); gaps.delete();
    en_total = 0; onehot_bad = 0; forbid_hits = 0; end_k = -1;
    busy_k1 = 1'bx; done_k1 = 1'bx; fail_k1 = 1'bx;
    prev = '0; run_len = 0; gap_len = 0; seen = 0;
    lane_mask = mask; timeout_limit = limit;
    for (int k = 0; k < max_k; k++) begin
      @(negedge SCLK);
      cur = {rdlvl_en, gate_en};
      if (k == 1) begin busy_k1 = busy; done_k1 = done; fail_k1 = fail; end
      if (!$onehot0(cur)) onehot_bad++;
      if (((cur[3:0] | cur[7:4]) & forbid) != 4'b0) forbid_hits++;
      if (cur != 8'h00) begin
        en_total++;
        if (prev == 8'h00) begin
          order.push_back(cur);
          if (seen) gaps.push_back(gap_len);
          run_len = 0;
        end
        run_len++;
      end else begin
        if (prev != 8'h00) begin durs.push_back(run_len); gap_len = 0; seen = 1; end
        gap_len++;
      end
      prev = cur;
      start = (k == 0) || (k == restart_at);
      if (k == restart_at) lane_mask = restart_mask;
      stray_resp = (k == stray_at) ? stray_vec : 4'b0;
      lane_error = (k == error_at) ? error_vec : 4'b0;
      if (k >= 2 && (done || fail)) begin end_k = k; break; end
    end
    start = 1'b0; stray_resp = '0; lane_error = '0;
    restart_at = -1; stray_at = -1; error_at = -1; forbid = '0;
  endtask

  task automatic test_reset();
    #1;
    vectors++; if ({gate_en, rdlvl_en, busy, done, fail, fail_lane, fail_cause, fail_phase, cur_lane} !== 22'd0) begin miscompares++; $display("[TB] FAIL reset_outputs_async: got %h want 0", {gate_en, rdlvl_en, busy, done, fail, fail_lane, fail_cause, fail_phase, cur_lane}); end
    repeat (3) @(negedge SCLK);
    vectors++; if ({gate_en, rdlvl_en, busy, done, fail, fail_lane, fail_cause, fail_phase, cur_lane} !== 22'd0) begin miscompares++; $display("[TB] FAIL reset_outputs_clocked: got %h want 0", {gate_en, rdlvl_en, busy, done, fail, fail_lane, fail_cause, fail_phase, cur_lane}); end
    reset_n = 1'b1;
    @(negedge SCLK);
    vectors++; if ({busy, done, fail} !== 3'b000) begin miscompares++; $display("[TB] FAIL idle_after_reset: got %b want 000", {busy, done, fail}); end
  endtask

  task automatic test_sweep_order();
    logic [7:0] exp_o [6];
    int exp_g [5];
    exp_o = '{8'h01, 8'h10, 8'h02, 8'h20, 8'h08, 8'h80};
    exp_g = '{4, 5, 4, 5, 4};
    gate_delay = 10; rdlvl_delay = 10; forbid = 4'b0100;
    run_sweep(4'b1011, 16'd0, 500);
    vectors++; if (busy_k1 !== 1'b1) begin miscompares++; $display("[TB] FAIL sweep_busy_n1: got %b want 1", busy_k1); end
    vectors++; if (order.size() != 6) begin miscompares++; $display("[TB] FAIL sweep_phase_count: got %0d want 6", order.size()); end
    for (int i = 0; i < 6; i++) begin
      vectors++; if (((i < order.size()) ? order[i] : 8'hff) !== exp_o[i]) begin miscompares++; $display("[TB] FAIL sweep_order[%0d]: got %h want %h", i, (i < order.size()) ? order[i] : 8'hff, exp_o[i]); end
      vectors++; if (((i < durs.size()) ? durs[i] : -1) != 11) begin miscompares++; $display("[TB] FAIL sweep_dur[%0d]: got %0d want 11", i, (i < durs.size()) ? durs[i] : -1); end
    end
    for (int i = 0; i < 5; i++) begin
      vectors++; if (((i < gaps.size()) ? gaps[i] : -1) != exp_g[i]) begin miscompares++; $display("[TB] FAIL sweep_gap[%0d]: got %0d want %0d", i, (i < gaps.size()) ? gaps[i] : -1, exp_g[i]); end
    end
    vectors++; if (en_total != 66) begin miscompares++; $display("[TB] FAIL sweep_enable_cycles: got %0d want 66", en_total); end
    vectors++; if (forbid_hits != 0) begin miscompares++; $display("[TB] FAIL sweep_lane2_enabled: got %0d want 0", forbid_hits); end
    vectors++; if (onehot_bad != 0) begin miscompares++; $display("[TB] FAIL sweep_onehot: got %0d want 0", onehot_bad); end
    vectors++; if (end_k != 95) begin miscompares++; $display("[TB] FAIL sweep_done_cycle: got %0d want 95", end_k); end
    vectors++; if ({done, fail, busy} !== 3'b100) begin miscompares++; $display("[TB] FAIL sweep_status: got %b want 100", {done, fail, busy}); end
    vectors++; if (cur_lane !== 3'd3) begin miscompares++; $display("[TB] FAIL sweep_cur_lane: got %0d want 3", cur_lane); end
  endtask

  task automatic test_zero_mask();
    forbid = 4'b1111;
    run_sweep(4'b0000, 16'd0, 50);
    vectors++; if ({busy_k1, done_k1} !== 2'b10) begin miscompares++; $display("[TB] FAIL zero_busy_done_n1: got %b want 10", {busy_k1, done_k1}); end
    vectors++; if (end_k != 2) begin miscompares++; $display("[TB] FAIL zero_done_cycle: got %0d want 2", end_k); end
    vectors++; if (en_total != 0) begin miscompares++; $display("[TB] FAIL zero_enables: got %0d want 0", en_total); end
    vectors++; if ({done, fail, busy} !== 3'b100) begin miscompares++; $display("[TB] FAIL zero_status: got %b want 100", {done, fail, busy}); end
  endtask

  task automatic test_timeout();
    gate_delay = 10; rdlvl_delay = -1; forbid = 4'b1101;
    run_sweep(4'b0010, 16'd20, 500);
    vectors++; if (order.size() != 2 || order[0] !== 8'h02 || order[1] !== 8'h20) begin miscompares++; $display("[TB] FAIL tmo_order: got %0d phases want 02,20", order.size()); end
    vectors++; if (durs.size() != 2 || durs[0] != 11 || durs[1] != 20) begin miscompares++; $display("[TB] FAIL tmo_durations: got %0d entries want 11,20", durs.size()); end
    vectors++; if (end_k != 37) begin miscompares++; $display("[TB] FAIL tmo_fail_cycle: got %0d want 37", end_k); end
    vectors++; if ({fail, done, busy} !== 3'b100) begin miscompares++; $display("[TB] FAIL tmo_status: got %b want 100", {fail, done, busy}); end
    vectors++; if ({fail_lane, fail_cause, fail_phase} !== {3'd1, 2'b10, 1'b1}) begin miscompares++; $display("[TB] FAIL tmo_record: got lane %0d cause %b phase %b want 1 10 1", fail_lane, fail_cause, fail_phase); end
    vectors++; if ({gate_en, rdlvl_en} !== 8'h00) begin miscompares++; $display("[TB] FAIL tmo_enables: got %h want 00", {gate_en, rdlvl_en}); end
    rdlvl_delay = 10;
  endtask

  task automatic test_error_priority();
    gate_delay = -1; rdlvl_delay = 10;
    error_at = 5; error_vec = 4'b0001; stray_at = 5; stray_vec = 4'b0001;
    run_sweep(4'b0001, 16'd0, 100);
    vectors++; if (fail_k1 !== 1'b0) begin miscompares++; $display("[TB] FAIL err_fail_cleared: got %b want 0", fail_k1); end
    vectors++; if (end_k != 6) begin miscompares++; $display("[TB] FAIL err_fail_cycle: got %0d want 6", end_k); end
    vectors++; if (durs.size() != 1 || durs[0] != 4) begin miscompares++; $display("[TB] FAIL err_gate_duration: got %0d entries want 4", durs.size()); end
    vectors++; if ({fail, done, busy} !== 3'b100) begin miscompares++; $display("[TB] FAIL err_status: got %b want 100", {fail, done, busy}); end
    vectors++; if ({fail_lane, fail_cause, fail_phase} !== {3'd0, 2'b01, 1'b0}) begin miscompares++; $display("[TB] FAIL err_record: got lane %0d cause %b phase %b want 0 01 0", fail_lane, fail_cause, fail_phase); end
    gate_delay = 10;
  endtask

  task automatic test_stray_restart();
    logic [7:0] exp_o [4];
    exp_o = '{8'h01, 8'h10, 8'h04, 8'h40};
    gate_delay = 10; rdlvl_delay = 10; forbid = 4'b1010;
    stray_at = 5; stray_vec = 4'b0100; restart_at = 20; restart_mask = 4'b1000;
    run_sweep(4'b0101, 16'd0, 500);
    vectors++; if (order.size() != 4) begin miscompares++; $display("[TB] FAIL stray_phase_count: got %0d want 4", order.size()); end
    for (int i = 0; i < 4; i++) begin
      vectors++; if (((i < order.size()) ? order[i] : 8'hff) !== exp_o[i] || ((i < durs.size()) ? durs[i] : -1) != 11) begin miscompares++; $display("[TB] FAIL stray_phase[%0d]: got %h/%0d want %h/11", i, (i < order.size()) ? order[i] : 8'hff, (i < durs.size()) ? durs[i] : -1, exp_o[i]); end
    end
    vectors++; if (forbid_hits != 0) begin miscompares++; $display("[TB] FAIL stray_forbidden_lane: got %0d want 0", forbid_hits); end
    vectors++; if (end_k != 64) begin miscompares++; $display("[TB] FAIL stray_done_cycle: got %0d want 64", end_k); end
    vectors++; if ({done, fail} !== 2'b10) begin miscompares++; $display("[TB] FAIL stray_status: got %b want 10", {done, fail}); end
  endtask

  task automatic test_async_reset();
    logic [7:0] exp_o [8];
    exp_o = '{8'h01, 8'h10, 8'h02, 8'h20, 8'h04, 8'h40, 8'h08, 8'h80};
    lane_mask = 4'b0110; timeout_limit = '0;
    @(negedge SCLK); start = 1'b1;
    @(negedge SCLK); start = 1'b0;
    @(negedge SCLK);
    vectors++; if (gate_en !== 4'b0010) begin miscompares++; $display("[TB] FAIL areset_gate_lane1: got %b want 0010", gate_en); end
    @(negedge SCLK);
    #1 reset_n = 1'b0;
    #1;
    vectors++; if ({gate_en, rdlvl_en, busy, cur_lane} !== 12'd0) begin miscompares++; $display("[TB] FAIL areset_immediate: got %h want 0", {gate_en, rdlvl_en, busy, cur_lane}); end
    @(negedge SCLK); reset_n = 1'b1;
    vectors++; if ({done, fail, fail_cause} !== 4'b0) begin miscompares++; $display("[TB] FAIL areset_no_result: got %b want 0000", {done, fail, fail_cause}); end
    run_sweep(4'b1111, 16'd0, 500);
    vectors++; if (order.size() != 8) begin miscompares++; $display("[TB] FAIL areset_phase_count: got %0d want 8", order.size()); end
    for (int i = 0; i < 8; i++) begin
      vectors++; if (((i < order.size()) ? order[i] : 8'hff) !== exp_o[i]) begin miscompares++; $display("[TB] FAIL areset_order[%0d]: got %h want %h", i, (i < order.size()) ? order[i] : 8'hff, exp_o[i]); end
    end
    vectors++; if ({done, fail} !== 2'b10) begin miscompares++; $display("[TB] FAIL areset_status: got %b want 10", {done, fail}); end
  endtask

  task automatic test_no_timeout();
    gate_delay = 70000; rdlvl_delay = 10;
    run_sweep(4'b0001, 16'd0, 75000);
    vectors++; if (durs.size() != 2 || durs[0] != 70001 || durs[1] != 11) begin miscompares++; $display("[TB] FAIL notmo_durations: got %0d entries first %0d want 70001,11", durs.size(), (durs.size() > 0) ? durs[0] : -1); end
    vectors++; if (end_k != 70023) begin miscompares++; $display("[TB] FAIL notmo_done_cycle: got %0d want 70023", end_k); end
    vectors++; if ({done, fail} !== 2'b10) begin miscompares++; $display("[TB] FAIL notmo_status: got %b want 10", {done, fail}); end
    gate_delay = 10;
  endtask

  // Scenario sequence followed by the summary.
  initial begin
    test_reset();
    test_sweep_order();
    test_zero_mask();
    test_timeout();
    test_error_priority();
    test_stray_restart();
    test_async_reset();
    test_no_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
